// File: rtl/gerador_pulsos_botao.sv
// Programmable burst generator of fixed-width botao pulses for the circuito counter.
// Every output is a flop; next-state and next-output logic live in one always_comb.
module gerador_pulsos_botao #(
  parameter int unsigned LARGURA_N = 4,
  parameter int unsigned T_ALTO    = 1,
  parameter int unsigned T_BAIXO   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 iniciar,
  input  logic [LARGURA_N-1:0] num_pulsos,
  output logic                 botao,
  output logic                 ocupado,
  output logic                 concluido,
  output logic [LARGURA_N-1:0] pulsos_emitidos
);

  localparam int unsigned T_MAX = (T_ALTO > T_BAIXO) ? T_ALTO : T_BAIXO;
  localparam int unsigned TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;
  localparam logic [TW-1:0] CARGA_ALTO  = TW'(T_ALTO - 1);
  localparam logic [TW-1:0] CARGA_BAIXO = TW'(T_BAIXO - 1);

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    ALTO   = 2'd1,
    BAIXO  = 2'd2
  } estado_t;

  estado_t                estado_q, estado_d;
  logic [LARGURA_N-1:0]   restantes_q, restantes_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [LARGURA_N-1:0]   pulsos_q, pulsos_d;
  logic                   concluido_q, concluido_d;
  logic                   botao_q, botao_d;
  logic                   ocupado_q, ocupado_d;

  always_comb begin
    estado_d    = estado_q;
    restantes_d = restantes_q;
    timer_d     = timer_q;
    pulsos_d    = pulsos_q;
    concluido_d = 1'b0;

    unique case (estado_q)
      OCIOSO: begin
        if (iniciar) begin
          pulsos_d = '0;
          if (num_pulsos != '0) begin
            restantes_d = num_pulsos;
            estado_d    = ALTO;
            timer_d     = CARGA_ALTO;
            pulsos_d    = LARGURA_N'(1);
          end else begin
            concluido_d = 1'b1;
          end
        end
      end
      ALTO: begin
        if (timer_q == '0) begin
          estado_d    = BAIXO;
          timer_d     = CARGA_BAIXO;
          restantes_d = restantes_q - LARGURA_N'(1);
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      BAIXO: begin
        if (timer_q == '0) begin
          if (restantes_q != '0) begin
            estado_d = ALTO;
            timer_d  = CARGA_ALTO;
            pulsos_d = pulsos_q + LARGURA_N'(1);
          end else begin
            estado_d    = OCIOSO;
            concluido_d = 1'b1;
          end
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: estado_d = OCIOSO;
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    botao_d   = (estado_d == ALTO);
    ocupado_d = (estado_d != OCIOSO);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q    <= OCIOSO;
      restantes_q <= '0;
      timer_q     <= '0;
      pulsos_q    <= '0;
      concluido_q <= 1'b0;
      botao_q     <= 1'b0;
      ocupado_q   <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      restantes_q <= restantes_d;
      timer_q     <= timer_d;
      pulsos_q    <= pulsos_d;
      concluido_q <= concluido_d;
      botao_q     <= botao_d;
      ocupado_q   <= ocupado_d;
    end
  end

  assign botao           = botao_q;
  assign ocupado         = ocupado_q;
  assign concluido       = concluido_q;
  assign pulsos_emitidos = pulsos_q;

endmodule

// File: tb/tb_gerador_pulsos_botao.sv
// Bench for gerador_pulsos_botao: default-timing and 3/2-timing instances checked
// every cycle against a cycle-offset model of the burst waveform.
module tb_gerador_pulsos_botao;

  localparam int PER0 = 2;  // T_ALTO=1, T_BAIXO=1
  localparam int TA0  = 1;
  localparam int PER1 = 5;  // T_ALTO=3, T_BAIXO=2
  localparam int TA1  = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ini0 = 1'b0, ini1 = 1'b0;
  logic [3:0] num0 = '0, num1 = '0;
  logic       b0, o0, c0, b1, o1, c1;
  logic [3:0] p0, p1;

  int n_tests = 0;
  int n_fail  = 0;

  int cyc = 0;
  int m_e0_0 = 0, m_n_0 = 0, m_e0_1 = 0, m_n_1 = 0;
  bit m_v_0 = 1'b0, m_v_1 = 1'b0;

  always #5 clk = ~clk;

  gerador_pulsos_botao #(.LARGURA_N(4), .T_ALTO(1), .T_BAIXO(1)) dut0 (
    .clk(clk), .reset(reset), .iniciar(ini0), .num_pulsos(num0),
    .botao(b0), .ocupado(o0), .concluido(c0), .pulsos_emitidos(p0)
  );

  gerador_pulsos_botao #(.LARGURA_N(4), .T_ALTO(3), .T_BAIXO(2)) dut1 (
    .clk(clk), .reset(reset), .iniciar(ini1), .num_pulsos(num1),
    .botao(b1), .ocupado(o1), .concluido(c1), .pulsos_emitidos(p1)
  );

  // Reference: a burst accepted at edge closing cycle c occupies cycles starting at e0=c+1;
  // a request is taken only when the previous burst's busy window has ended.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      m_v_0 <= 1'b0;
      m_v_1 <= 1'b0;
    end else begin
      if (ini0 && (!m_v_0 || (cyc - m_e0_0) >= m_n_0 * PER0)) begin
        m_v_0 <= 1'b1; m_e0_0 <= cyc + 1; m_n_0 <= int'(num0);
      end
      if (ini1 && (!m_v_1 || (cyc - m_e0_1) >= m_n_1 * PER1)) begin
        m_v_1 <= 1'b1; m_e0_1 <= cyc + 1; m_n_1 <= int'(num1);
      end
    end
  end

  task automatic check_dut(input string nm, input bit v, input int e0, input int n,
                           input int per, input int ta,
                           input logic b, input logic o, input logic c, input logic [3:0] p);
    logic       eb, eo, ec;
    logic [3:0] ep;
    int t, tot;
    eb = 1'b0; eo = 1'b0; ec = 1'b0; ep = '0;
    if (v) begin
      t   = cyc - e0;
      tot = n * per;
      eb  = (t < tot) && ((t % per) < ta);
      eo  = (t < tot);
      ec  = (t == tot);
      ep  = (t < tot) ? 4'(t / per + 1) : 4'(n);
    end
    n_tests++;
    assert (b === eb) else begin
      n_fail++; $error("FAIL %s botao cyc=%0d got=%b exp=%b", nm, cyc, b, eb);
    end
    n_tests++;
    assert (o === eo) else begin
      n_fail++; $error("FAIL %s ocupado cyc=%0d got=%b exp=%b", nm, cyc, o, eo);
    end
    n_tests++;
    assert (c === ec) else begin
      n_fail++; $error("FAIL %s concluido cyc=%0d got=%b exp=%b", nm, cyc, c, ec);
    end
    n_tests++;
    assert (p === ep) else begin
      n_fail++; $error("FAIL %s pulsos_emitidos cyc=%0d got=%0d exp=%0d", nm, cyc, p, ep);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      check_dut("dut0", m_v_0, m_e0_0, m_n_0, PER0, TA0, b0, o0, c0, p0);
      check_dut("dut1", m_v_1, m_e0_1, m_n_1, PER1, TA1, b1, o1, c1, p1);
    end
  endtask

  task automatic start0(input int n);
    num0 = 4'(n); ini0 = 1'b1; step(1); ini0 = 1'b0;
  endtask

  task automatic start1(input int n);
    num1 = 4'(n); ini1 = 1'b1; step(1); ini1 = 1'b0;
  endtask

  initial begin
    // Reset held two cycles, then idle.
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(20);

    // Eight single-cycle pulses on the default instance.
    start0(8);
    step(20);

    // Four 3-high/2-low pulses.
    start1(4);
    step(24);

    // Zero-length request on both instances.
    num0 = '0; num1 = '0; ini0 = 1'b1; ini1 = 1'b1;
    step(1);
    ini0 = 1'b0; ini1 = 1'b0;
    step(4);

    // Mid-burst re-request ignored, then back-to-back request on the concluido cycle.
    start0(3);
    step(2);
    num0 = 4'd15; ini0 = 1'b1;
    step(1);
    ini0 = 1'b0; num0 = 4'd3;
    step(3);
    ini0 = 1'b1;
    step(1);
    ini0 = 1'b0;
    step(8);

    // Reset during the second high phase, then a normal request.
    start0(5);
    step(2);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(2);
    start0(2);
    step(6);

    // Maximum count on both instances.
    num0 = 4'd15; num1 = 4'd15; ini0 = 1'b1; ini1 = 1'b1;
    step(1);
    ini0 = 1'b0; ini1 = 1'b0;
    step(80);

    // Random requests, counts and occasional resets.
    for (int i = 0; i < 400; i++) begin
      ini0  = ($urandom_range(0, 5) == 0);
      ini1  = ($urandom_range(0, 7) == 0);
      num0  = 4'($urandom_range(0, 15));
      num1  = 4'($urandom_range(0, 15));
      reset = ($urandom_range(0, 149) == 0);
      step(1);
    end
    reset = 1'b0; ini0 = 1'b0; ini1 = 1'b0;
    step(90);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
